// File: rtl/seq_pattern_tx_if.sv
// Command/status bundle for seq_pattern_tx: command inputs and serial/progress outputs.
// Signal names match the original flat ports so existing drivers map one-to-one.
interface seq_pattern_tx_if #(
    parameter int CNT_W = 4
) ();
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] repeat_n;
    logic [CNT_W-1:0] gap;
    logic             x;
    logic             valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output start, abort, repeat_n, gap,
        input  x, valid, busy, done, frame_cnt
    );

    modport slave (
        input  start, abort, repeat_n, gap,
        output x, valid, busy, done, frame_cnt
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends repeat_n frames of PATTERN (MSB first) with
// programmable idle gaps, reporting busy/done/frame_cnt; supports synchronous abort.
module seq_pattern_tx #(
    parameter int             PAT_W   = 6,
    parameter logic [PAT_W-1:0] PATTERN = 6'b101011,
    parameter int             CNT_W   = 4
) (
    input  logic          clk,
    input  logic          rst,
    seq_pattern_tx_if.slave bus
);
    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [CNT_W-1:0] r_rem, w_rem_nxt;
    logic [CNT_W-1:0] r_gcnt, w_gcnt_nxt;
    logic [CNT_W-1:0] r_gap_lat, w_gap_lat_nxt;
    logic [CNT_W-1:0] r_frame_cnt, w_frame_cnt_nxt;
    logic             r_x, w_x_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_rem       <= '0;
            r_gcnt      <= '0;
            r_gap_lat   <= '0;
            r_frame_cnt <= '0;
            r_x         <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_rem       <= w_rem_nxt;
            r_gcnt      <= w_gcnt_nxt;
            r_gap_lat   <= w_gap_lat_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_x         <= w_x_nxt;
            r_valid     <= w_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_rem_nxt       = r_rem;
        w_gcnt_nxt      = r_gcnt;
        w_gap_lat_nxt   = r_gap_lat;
        w_frame_cnt_nxt = r_frame_cnt;
        w_done_nxt      = 1'b0;

        // Abort truncates immediately; frame_cnt keeps whatever had completed.
        if (bus.abort) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.start && (bus.repeat_n != '0)) begin
                        w_state_nxt     = SEND;
                        w_rem_nxt       = bus.repeat_n;
                        w_gap_lat_nxt   = bus.gap;
                        w_frame_cnt_nxt = '0;
                        w_idx_nxt       = IDX_LAST;
                    end
                end
                SEND: begin
                    if (r_idx != '0) begin
                        w_idx_nxt = r_idx - IDX_W'(1);
                    end else begin
                        w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
                        w_rem_nxt       = r_rem - CNT_W'(1);
                        if (r_rem == CNT_W'(1)) begin
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                        end else if (r_gap_lat == '0) begin
                            w_idx_nxt = IDX_LAST;
                        end else begin
                            w_state_nxt = GAP;
                            w_gcnt_nxt  = r_gap_lat;
                        end
                    end
                end
                GAP: begin
                    w_gcnt_nxt = r_gcnt - CNT_W'(1);
                    if (r_gcnt == CNT_W'(1)) begin
                        w_state_nxt = SEND;
                        w_idx_nxt   = IDX_LAST;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        w_valid_nxt = (w_state_nxt == SEND);
        w_busy_nxt  = (w_state_nxt != IDLE);
        w_x_nxt     = w_valid_nxt & PATTERN[w_idx_nxt];
    end

    assign bus.x         = r_x;
    assign bus.valid     = r_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: directed vector table, hand-written
// corner sequences and randomized commands against a frame-level trace model.
module tb_seq_pattern_tx;
    localparam logic [5:0] PAT = 6'b101011;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seq_pattern_tx_if #(.CNT_W(4)) bus ();

    seq_pattern_tx #(
        .PAT_W  (6),
        .PATTERN(6'b101011),
        .CNT_W  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record layout: {x, valid, busy, done, frame_cnt[3:0]}
    typedef struct {
        logic       r;
        logic       s;
        logic       a;
        logic [3:0] n;
        logic [3:0] g;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl[14];
    logic [7:0] cur;
    logic [7:0] exp_q[$];
    logic [7:0] dv;

    function automatic logic [7:0] mk(input logic x, input logic v, input logic b,
                                      input logic d, input logic [3:0] f);
        return {x, v, b, d, f};
    endfunction

    function automatic vec_t tv(input logic r, input logic s, input logic [3:0] n,
                                input logic [7:0] e);
        vec_t t;
        t.r = r; t.s = s; t.a = 1'b0; t.n = n; t.g = 4'd0; t.exp = e;
        return t;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got {x,v,b,d,fc}=%b_%b_%b_%b_%0d expected %b_%b_%b_%b_%0d",
                     name, $time, got[7], got[6], got[5], got[4], got[3:0],
                     want[7], want[6], want[5], want[4], want[3:0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic a,
                         input logic [3:0] n, input logic [3:0] g);
        rst          = r;
        bus.start    = s;
        bus.abort    = a;
        bus.repeat_n = n;
        bus.gap      = g;
    endtask

    // Reference: an accepted command expands into the complete expected output trace.
    task automatic model_next(input logic r, input logic s, input logic a,
                              input logic [3:0] n, input logic [3:0] g);
        if (r) begin
            exp_q.delete();
            cur = '0;
        end else if (a) begin
            exp_q.delete();
            cur = mk(1'b0, 1'b0, 1'b0, 1'b0, cur[3:0]);
        end else if (!cur[5] && s && n != 4'd0) begin
            for (int f = 0; f < int'(n); f++) begin
                for (int b = 5; b >= 0; b--)
                    exp_q.push_back(mk(PAT[b], 1'b1, 1'b1, 1'b0, 4'(f)));
                if (f < int'(n) - 1)
                    for (int k = 0; k < int'(g); k++)
                        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 4'(f + 1)));
            end
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, n));
            cur = exp_q.pop_front();
        end else if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
        end else begin
            cur = mk(1'b0, 1'b0, 1'b0, 1'b0, cur[3:0]);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic a,
                        input logic [3:0] n, input logic [3:0] g);
        drive(r, s, a, n, g);
        model_next(r, s, a, n, g);
        @(posedge clk);
        @(negedge clk);
        dv = {bus.x, bus.valid, bus.busy, bus.done, bus.frame_cnt};
        check("model", dv, cur);
    endtask

    initial begin
        int busy_cnt;
        int valid_cnt;
        int done_cnt;
        int done_cyc;
        int guard;

        checks = 0;
        errors = 0;
        cur    = '0;
        drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);

        // Reset with start held, quiet after release, single frame, ignored n=0.
        tbl[0]  = tv(1'b1, 1'b1, 4'd1, mk(0, 0, 0, 0, 4'd0));
        tbl[1]  = tv(1'b1, 1'b1, 4'd1, mk(0, 0, 0, 0, 4'd0));
        tbl[2]  = tv(1'b0, 1'b0, 4'd1, mk(0, 0, 0, 0, 4'd0));
        tbl[3]  = tv(1'b0, 1'b0, 4'd1, mk(0, 0, 0, 0, 4'd0));
        tbl[4]  = tv(1'b0, 1'b1, 4'd1, mk(1, 1, 1, 0, 4'd0));
        tbl[5]  = tv(1'b0, 1'b0, 4'd1, mk(0, 1, 1, 0, 4'd0));
        tbl[6]  = tv(1'b0, 1'b0, 4'd1, mk(1, 1, 1, 0, 4'd0));
        tbl[7]  = tv(1'b0, 1'b0, 4'd1, mk(0, 1, 1, 0, 4'd0));
        tbl[8]  = tv(1'b0, 1'b0, 4'd1, mk(1, 1, 1, 0, 4'd0));
        tbl[9]  = tv(1'b0, 1'b0, 4'd1, mk(1, 1, 1, 0, 4'd0));
        tbl[10] = tv(1'b0, 1'b0, 4'd1, mk(0, 0, 0, 1, 4'd1));
        tbl[11] = tv(1'b0, 1'b0, 4'd1, mk(0, 0, 0, 0, 4'd1));
        tbl[12] = tv(1'b0, 1'b1, 4'd0, mk(0, 0, 0, 0, 4'd1));
        tbl[13] = tv(1'b0, 1'b0, 4'd0, mk(0, 0, 0, 0, 4'd1));

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].n, tbl[i].g);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("tbl%0d", i),
                  {bus.x, bus.valid, bus.busy, bus.done, bus.frame_cnt}, tbl[i].exp);
        end

        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);

        // Back-to-back frames.
        busy_cnt = 0; valid_cnt = 0; done_cnt = 0;
        step(1'b0, 1'b1, 1'b0, 4'd3, 4'd0);
        for (int c = 0; c < 22; c++) begin
            busy_cnt  += int'(dv[5]);
            valid_cnt += int'(dv[6]);
            done_cnt  += int'(dv[4]);
            step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        end
        check_int("b2b_busy", busy_cnt, 18);
        check_int("b2b_valid", valid_cnt, 18);
        check_int("b2b_done", done_cnt, 1);

        // Gapped frames; done must land on cycle 16 after the start edge.
        busy_cnt = 0; done_cyc = 0;
        step(1'b0, 1'b1, 1'b0, 4'd2, 4'd3);
        for (int c = 1; c <= 18; c++) begin
            busy_cnt += int'(dv[5]);
            if (dv[4]) done_cyc = c;
            step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        end
        check_int("gap_busy", busy_cnt, 15);
        check_int("gap_done_cycle", done_cyc, 16);

        // Start mid-frame with different parameters, and start in the done cycle.
        step(1'b0, 1'b1, 1'b0, 4'd2, 4'd2);
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        step(1'b0, 1'b1, 1'b0, 4'd5, 4'd0);
        guard = 0;
        while (!dv[4] && guard < 40) begin
            step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
            guard++;
        end
        check_int("stray_done_seen", int'(dv[4]), 1);
        check_int("stray_frames", int'(dv[3:0]), 2);
        step(1'b0, 1'b1, 1'b0, 4'd1, 4'd0);
        check_int("restart_in_done", int'(dv[6]), 1);
        for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

        // Abort on the 4th bit of frame 2 (cycle 11), then restart two cycles later.
        step(1'b0, 1'b1, 1'b0, 4'd2, 4'd1);
        for (int c = 2; c <= 11; c++) step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
        check_int("abort_frame_cnt", int'(dv[3:0]), 1);
        check_int("abort_idle", int'(dv[7:4]), 0);
        done_cnt = 0;
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        done_cnt += int'(dv[4]);
        check_int("abort_no_done", done_cnt, 0);
        valid_cnt = 0;
        step(1'b0, 1'b1, 1'b0, 4'd2, 4'd1);
        for (int c = 0; c < 16; c++) begin
            valid_cnt += int'(dv[6]);
            step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        end
        check_int("after_abort_valid", valid_cnt, 12);

        // Randomized commands with stray starts, aborts and occasional resets.
        for (int cmd = 0; cmd < 60; cmd++) begin
            logic [3:0] n;
            logic [3:0] g;
            n = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
            g = 4'($urandom_range(0, 3));
            step(1'b0, 1'b1, 1'b0, n, g);
            guard = 0;
            while ((cur[5] || exp_q.size() != 0) && guard < 400) begin
                logic r, s, a;
                r = ($urandom_range(0, 299) == 0);
                a = ($urandom_range(0, 79) == 0);
                s = ($urandom_range(0, 7) == 0);
                step(r, s, a, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                guard++;
            end
            check_int("rand_bound", int'(guard < 400), 1);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++)
                step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
